// File: rtl/asp_corr_port_if.sv
// ---------------------------------------------------------------------------
// asp_corr_port_if
//
// Bus between the Nios PIO block and the correlation node responder.
//   addr_in  [7:0]  destination address (Nios "addr" PIO)
//   cmd_in   [31:0] command word        (Nios "send" PIO)
//   rsp_out  [31:0] response word       (Nios "recv" PIO)
//
// master : the Nios side (drives address/command, reads the response)
// slave  : the node (reads address/command, drives the response)
// ---------------------------------------------------------------------------
interface asp_corr_port_if;
    logic [7:0]  addr_in;
    logic [31:0] cmd_in;
    logic [31:0] rsp_out;

    modport master (
        output addr_in,
        output cmd_in,
        input  rsp_out
    );

    modport slave (
        input  addr_in,
        input  cmd_in,
        output rsp_out
    );
endinterface

// File: rtl/asp_corr_port.sv
// ---------------------------------------------------------------------------
// asp_corr_port
//
// Network-side responder for the correlation ASP node. Commands arrive as a
// toggle-qualified 32-bit word plus an 8-bit destination address. Two
// DEPTH x 16 sample buffers are filled with PUSH_A / PUSH_B, and START runs a
// sequential signed multiply-accumulate over both buffers. Every executed
// command is answered by flipping the ack bit of the response word.
//
// Parameters
//   NODE_ID  address this node answers to
//   DEPTH    samples per vector, power of two in 2..64
//
// Ports
//   clk_clk        single clock shared with the Nios system
//   reset_reset_n  asynchronous active-low reset
//   bus            asp_corr_port_if slave modport
//                    addr_in  destination address
//                    cmd_in   {tog, opcode[2:0], reserved[11:0], data[15:0]}
//                    rsp_out  {ack, busy, done, error, 12'h0, data[15:0]}
//
// Pipeline / timing (E = edge that first registers a new toggle value)
//   E      cmd_in / addr_in captured
//   E+1    decode in IDLE, state updated, response staged in pend_* regs
//   E+2    rsp_out updated from the staged response
//   START: MAC reads at E+2..E+DEPTH+1, two FLUSH edges, ack at E+DEPTH+4.
// ---------------------------------------------------------------------------
module asp_corr_port #(
    parameter logic [7:0] NODE_ID = 8'h01,
    parameter int         DEPTH   = 16
) (
    input  logic             clk_clk,
    input  logic             reset_reset_n,
    asp_corr_port_if.slave   bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] PTR_FULL = PW'(DEPTH);
    localparam logic [AW-1:0] IDX_LAST = AW'(DEPTH - 1);

    localparam logic [2:0] OP_CLEAR   = 3'd0;
    localparam logic [2:0] OP_PUSH_A  = 3'd1;
    localparam logic [2:0] OP_PUSH_B  = 3'd2;
    localparam logic [2:0] OP_START   = 3'd3;
    localparam logic [2:0] OP_READ_LO = 3'd4;
    localparam logic [2:0] OP_READ_HI = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MAC   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    // Only the toggle, opcode and data fields of the command are kept.
    logic [7:0]         addr_reg;
    logic               tog_reg;
    logic [2:0]         op_reg;
    logic [15:0]        data_reg;

    state_t             state_reg;
    logic               last_tog_reg;
    logic [PW-1:0]      wptr_a_reg;
    logic [PW-1:0]      wptr_b_reg;
    logic [31:0]        acc_reg;
    logic               done_reg;
    logic [AW-1:0]      mac_idx_reg;
    logic               flush_cnt_reg;

    // MAC datapath pipeline: buffer read -> product -> accumulate
    logic [15:0]        rd_a_reg;
    logic [15:0]        rd_b_reg;
    logic               rd_vld_reg;
    logic signed [31:0] prod_reg;
    logic               prod_vld_reg;

    // Response staged one cycle ahead of rsp_out
    logic               pend_vld_reg;
    logic               pend_ack_reg;
    logic               pend_busy_reg;
    logic               pend_done_reg;
    logic               pend_err_reg;
    logic [15:0]        pend_data_reg;
    logic [31:0]        rsp_reg;

    // Sample buffers: one write port (command decode), one read port (MAC)
    logic [15:0]        buf_a [DEPTH];
    logic [15:0]        buf_b [DEPTH];

    // Reserved command bits are deliberately ignored.
    logic               unused_reserved;
    assign unused_reserved = ^bus.cmd_in[27:16];

    // -----------------------------------------------------------------------
    // Command decode (combinational, from registered copies)
    // -----------------------------------------------------------------------
    logic               new_cmd;
    logic               exec_cmd;
    logic               a_full;
    logic               b_full;
    logic               wr_a_en;
    logic               wr_b_en;
    logic signed [31:0] a_ext;
    logic signed [31:0] b_ext;

    always_comb begin
        new_cmd  = (state_reg == ST_IDLE) && (tog_reg != last_tog_reg);
        exec_cmd = new_cmd && (addr_reg == NODE_ID);
        a_full   = (wptr_a_reg == PTR_FULL);
        b_full   = (wptr_b_reg == PTR_FULL);
        wr_a_en  = exec_cmd && (op_reg == OP_PUSH_A) && !a_full;
        wr_b_en  = exec_cmd && (op_reg == OP_PUSH_B) && !b_full;
        a_ext    = {{16{rd_a_reg[15]}}, rd_a_reg};
        b_ext    = {{16{rd_b_reg[15]}}, rd_b_reg};
    end

    // -----------------------------------------------------------------------
    // Buffer RAMs (no reset so they map onto block RAM)
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_clk) begin
        if (wr_a_en) begin
            buf_a[wptr_a_reg[AW-1:0]] <= data_reg;
        end
        if (wr_b_en) begin
            buf_b[wptr_b_reg[AW-1:0]] <= data_reg;
        end
        rd_a_reg <= buf_a[mac_idx_reg];
        rd_b_reg <= buf_b[mac_idx_reg];
    end

    // -----------------------------------------------------------------------
    // Control FSM, MAC pipeline and response register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            addr_reg      <= 8'h00;
            tog_reg       <= 1'b0;
            op_reg        <= 3'd0;
            data_reg      <= 16'h0000;
            state_reg     <= ST_IDLE;
            last_tog_reg  <= 1'b0;
            wptr_a_reg    <= '0;
            wptr_b_reg    <= '0;
            acc_reg       <= 32'h0;
            done_reg      <= 1'b0;
            mac_idx_reg   <= '0;
            flush_cnt_reg <= 1'b0;
            rd_vld_reg    <= 1'b0;
            prod_reg      <= 32'sh0;
            prod_vld_reg  <= 1'b0;
            pend_vld_reg  <= 1'b0;
            pend_ack_reg  <= 1'b0;
            pend_busy_reg <= 1'b0;
            pend_done_reg <= 1'b0;
            pend_err_reg  <= 1'b0;
            pend_data_reg <= 16'h0000;
            rsp_reg       <= 32'h0;
        end else begin
            // Input capture every cycle
            addr_reg <= bus.addr_in;
            tog_reg  <= bus.cmd_in[31];
            op_reg   <= bus.cmd_in[30:28];
            data_reg <= bus.cmd_in[15:0];

            // MAC datapath runs freely; valid bits gate the accumulate.
            rd_vld_reg   <= 1'b0;
            prod_vld_reg <= rd_vld_reg;
            prod_reg     <= a_ext * b_ext;
            if (prod_vld_reg) begin
                acc_reg <= acc_reg + prod_reg;
            end

            // Publish the response staged on the previous edge. A staged
            // response without pend_ack is the busy-only update of START.
            pend_vld_reg <= 1'b0;
            if (pend_vld_reg) begin
                rsp_reg <= {rsp_reg[31] ^ pend_ack_reg, pend_busy_reg,
                            pend_done_reg, pend_err_reg, 12'h000,
                            pend_data_reg};
            end

            unique case (state_reg)
                ST_IDLE: begin
                    if (new_cmd) begin
                        // The toggle is consumed even for other nodes'
                        // commands so they are never re-detected.
                        last_tog_reg <= tog_reg;
                    end
                    if (exec_cmd) begin
                        pend_vld_reg  <= 1'b1;
                        pend_ack_reg  <= 1'b1;
                        pend_busy_reg <= 1'b0;
                        pend_done_reg <= done_reg;
                        pend_err_reg  <= 1'b0;
                        pend_data_reg <= 16'h0000;
                        case (op_reg)
                            OP_CLEAR: begin
                                wptr_a_reg    <= '0;
                                wptr_b_reg    <= '0;
                                acc_reg       <= 32'h0;
                                done_reg      <= 1'b0;
                                pend_done_reg <= 1'b0;
                            end
                            OP_PUSH_A: begin
                                if (a_full) begin
                                    pend_err_reg <= 1'b1;
                                end else begin
                                    wptr_a_reg    <= wptr_a_reg + PW'(1);
                                    done_reg      <= 1'b0;
                                    pend_done_reg <= 1'b0;
                                end
                            end
                            OP_PUSH_B: begin
                                if (b_full) begin
                                    pend_err_reg <= 1'b1;
                                end else begin
                                    wptr_b_reg    <= wptr_b_reg + PW'(1);
                                    done_reg      <= 1'b0;
                                    pend_done_reg <= 1'b0;
                                end
                            end
                            OP_START: begin
                                if (a_full && b_full) begin
                                    // Busy is shown now; the ack comes
                                    // when the accumulation has drained.
                                    acc_reg       <= 32'h0;
                                    mac_idx_reg   <= '0;
                                    state_reg     <= ST_MAC;
                                    pend_ack_reg  <= 1'b0;
                                    pend_busy_reg <= 1'b1;
                                end else begin
                                    pend_err_reg <= 1'b1;
                                end
                            end
                            OP_READ_LO: pend_data_reg <= acc_reg[15:0];
                            OP_READ_HI: pend_data_reg <= acc_reg[31:16];
                            default:    pend_err_reg  <= 1'b1;
                        endcase
                    end
                end

                ST_MAC: begin
                    // mac_idx_reg addresses both RAMs this cycle
                    rd_vld_reg  <= 1'b1;
                    mac_idx_reg <= mac_idx_reg + AW'(1);
                    if (mac_idx_reg == IDX_LAST) begin
                        flush_cnt_reg <= 1'b0;
                        state_reg     <= ST_FLUSH;
                    end
                end

                ST_FLUSH: begin
                    // First edge forms the last product, second adds it.
                    if (!flush_cnt_reg) begin
                        flush_cnt_reg <= 1'b1;
                    end else begin
                        state_reg     <= ST_IDLE;
                        done_reg      <= 1'b1;
                        pend_vld_reg  <= 1'b1;
                        pend_ack_reg  <= 1'b1;
                        pend_busy_reg <= 1'b0;
                        pend_done_reg <= 1'b1;
                        pend_err_reg  <= 1'b0;
                        pend_data_reg <= 16'h0000;
                    end
                end

                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign bus.rsp_out = rsp_reg;

endmodule

// File: tb/tb_asp_corr_port.sv
// ---------------------------------------------------------------------------
// tb_asp_corr_port
//
// Directed bench for asp_corr_port (NODE_ID=1, DEPTH=4). The stimulus side
// pushes each expected response word, together with the cycle at which it
// must appear, into a queue. A monitor pops an entry whenever rsp_out
// changes and compares word and cycle.
// ---------------------------------------------------------------------------
module tb_asp_corr_port;

    localparam int DEPTH = 4;

    localparam logic [2:0] OP_CLEAR   = 3'd0;
    localparam logic [2:0] OP_PUSH_A  = 3'd1;
    localparam logic [2:0] OP_PUSH_B  = 3'd2;
    localparam logic [2:0] OP_START   = 3'd3;
    localparam logic [2:0] OP_READ_LO = 3'd4;
    localparam logic [2:0] OP_READ_HI = 3'd5;

    typedef struct {
        logic [31:0] w;
        int          at;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    logic        tog    = 1'b0;
    logic        m_ack  = 1'b0;
    logic [31:0] last_w = 32'h0;
    exp_t        q [$];

    asp_corr_port_if bus ();

    asp_corr_port #(
        .NODE_ID (8'h01),
        .DEPTH   (DEPTH)
    ) dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .bus           (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // -----------------------------------------------------------------------
    // Monitor
    // -----------------------------------------------------------------------
    logic [31:0] prev_rsp = 32'h0;
    exp_t        mon_ent;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_rsp = bus.rsp_out;
        end else if (bus.rsp_out !== prev_rsp) begin
            n_cmp++;
            if (q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_rsp: got %h at cycle %0d, required no change from %h",
                         bus.rsp_out, cyc, prev_rsp);
            end else begin
                mon_ent = q.pop_front();
                if (bus.rsp_out !== mon_ent.w || cyc != mon_ent.at) begin
                    n_err++;
                    $display("FAIL rsp: got %h at cycle %0d, required %h at cycle %0d",
                             bus.rsp_out, cyc, mon_ent.w, mon_ent.at);
                end else begin
                    $display("ok   rsp: %h at cycle %0d", bus.rsp_out, cyc);
                end
            end
            prev_rsp = bus.rsp_out;
        end
    end

    // -----------------------------------------------------------------------
    // Stimulus helpers
    // -----------------------------------------------------------------------
    task automatic issue(input logic [7:0] a, input logic [2:0] op,
                         input logic [15:0] d, output int e);
        tog         = ~tog;
        bus.addr_in = a;
        bus.cmd_in  = {tog, op, 12'h000, d};
        e           = cyc + 1;
    endtask

    task automatic exp_ack(input int at, input logic done, input logic err,
                           input logic [15:0] data);
        exp_t t;
        m_ack  = ~m_ack;
        t.w    = {m_ack, 1'b0, done, err, 12'h000, data};
        t.at   = at;
        last_w = t.w;
        q.push_back(t);
    endtask

    task automatic exp_busy(input int at, input logic done);
        exp_t t;
        t.w    = {m_ack, 1'b1, done, 1'b0, 12'h000, 16'h0000};
        t.at   = at;
        last_w = t.w;
        q.push_back(t);
    endtask

    task automatic wait_empty(input string name);
        int n;
        n = 0;
        while (q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL timeout_%s: got %0d responses outstanding, required 0",
                     name, q.size());
            q.delete();
        end
    endtask

    task automatic do_cmd(input logic [2:0] op, input logic [15:0] d,
                          input logic done, input logic err,
                          input logic [15:0] data);
        int e;
        issue(8'h01, op, d, e);
        exp_ack(e + 2, done, err, data);
        wait_empty("cmd");
    endtask

    task automatic do_start(input logic done_before);
        int e;
        issue(8'h01, OP_START, 16'h0000, e);
        exp_busy(e + 2, done_before);
        exp_ack(e + DEPTH + 4, 1'b1, 1'b0, 16'h0000);
        wait_empty("start");
    endtask

    task automatic check_rsp(input string name, input logic [31:0] want);
        n_cmp++;
        if (bus.rsp_out !== want) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, bus.rsp_out, want);
        end else begin
            $display("ok   %s: %h", name, bus.rsp_out);
        end
    endtask

    task automatic load_1_to_8();
        for (int i = 0; i < DEPTH; i++) do_cmd(OP_PUSH_A, 16'(i + 1), 1'b0, 1'b0, 16'h0);
        for (int i = 0; i < DEPTH; i++) do_cmd(OP_PUSH_B, 16'(i + 5), 1'b0, 1'b0, 16'h0);
    endtask

    // -----------------------------------------------------------------------
    // Directed sequence
    // -----------------------------------------------------------------------
    initial begin
        int e;
        bus.addr_in = 8'h01;
        bus.cmd_in  = 32'h0;

        // Reset
        #2 rst_n = 1'b0;
        #1 check_rsp("reset_value", 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_rsp("after_release", 32'h0);

        // Basic dot product: 1*5+2*6+3*7+4*8 = 70
        do_cmd(OP_CLEAR, 16'h0, 1'b0, 1'b0, 16'h0);
        load_1_to_8();
        do_start(1'b0);
        do_cmd(OP_READ_LO, 16'h0, 1'b1, 1'b0, 16'h0046);
        do_cmd(OP_READ_HI, 16'h0, 1'b1, 1'b0, 16'h0000);

        // Signed: 4 * (-1 * 2) = -8
        do_cmd(OP_CLEAR, 16'h0, 1'b0, 1'b0, 16'h0);
        for (int i = 0; i < DEPTH; i++) do_cmd(OP_PUSH_A, 16'hFFFF, 1'b0, 1'b0, 16'h0);
        for (int i = 0; i < DEPTH; i++) do_cmd(OP_PUSH_B, 16'h0002, 1'b0, 1'b0, 16'h0);
        do_start(1'b0);
        do_cmd(OP_READ_LO, 16'h0, 1'b1, 1'b0, 16'hFFF8);
        do_cmd(OP_READ_HI, 16'h0, 1'b1, 1'b0, 16'hFFFF);

        // Wrap: 4 * 2^30 = 2^32 -> 0
        do_cmd(OP_CLEAR, 16'h0, 1'b0, 1'b0, 16'h0);
        for (int i = 0; i < DEPTH; i++) do_cmd(OP_PUSH_A, 16'h8000, 1'b0, 1'b0, 16'h0);
        for (int i = 0; i < DEPTH; i++) do_cmd(OP_PUSH_B, 16'h8000, 1'b0, 1'b0, 16'h0);
        do_start(1'b0);
        do_cmd(OP_READ_LO, 16'h0, 1'b1, 1'b0, 16'h0000);
        do_cmd(OP_READ_HI, 16'h0, 1'b1, 1'b0, 16'h0000);

        // Address filter: foreign PUSH_A must not ack nor move wptrA
        do_cmd(OP_CLEAR, 16'h0, 1'b0, 1'b0, 16'h0);
        issue(8'h02, OP_PUSH_A, 16'h1234, e);
        repeat (8) @(negedge clk);
        check_rsp("ignored_cmd", last_w);

        // Four matched pushes succeed only if wptrA is still 0; the fifth
        // must error and leave A untouched.
        do_cmd(OP_PUSH_A, 16'h0001, 1'b0, 1'b0, 16'h0);
        do_cmd(OP_PUSH_A, 16'hFFFF, 1'b0, 1'b0, 16'h0);
        do_cmd(OP_PUSH_A, 16'h0002, 1'b0, 1'b0, 16'h0);
        do_cmd(OP_PUSH_A, 16'h0003, 1'b0, 1'b0, 16'h0);
        do_cmd(OP_PUSH_A, 16'h7FFF, 1'b0, 1'b1, 16'h0);
        do_cmd(OP_PUSH_B, 16'd10, 1'b0, 1'b0, 16'h0);
        do_cmd(OP_PUSH_B, 16'd20, 1'b0, 1'b0, 16'h0);
        do_cmd(OP_PUSH_B, 16'd30, 1'b0, 1'b0, 16'h0);
        // START with wptrB=3: plain error ack, no busy phase
        do_cmd(OP_START, 16'h0, 1'b0, 1'b1, 16'h0);
        do_cmd(3'd7, 16'h0, 1'b0, 1'b1, 16'h0);
        do_cmd(OP_PUSH_B, 16'd40, 1'b0, 1'b0, 16'h0);
        // 10 - 20 + 60 + 120 = 170
        do_start(1'b0);
        do_cmd(OP_READ_LO, 16'h0, 1'b1, 1'b0, 16'h00AA);
        do_cmd(OP_READ_HI, 16'h0, 1'b1, 1'b0, 16'h0000);

        // Command toggled during MAC runs on the first IDLE edge afterwards
        do_cmd(OP_CLEAR, 16'h0, 1'b0, 1'b0, 16'h0);
        load_1_to_8();
        issue(8'h01, OP_START, 16'h0000, e);
        exp_busy(e + 2, 1'b0);
        exp_ack(e + DEPTH + 4, 1'b1, 1'b0, 16'h0000);
        repeat (3) @(negedge clk);
        begin
            int e2;
            issue(8'h01, OP_READ_LO, 16'h0000, e2);
        end
        exp_ack(e + DEPTH + 5, 1'b1, 1'b0, 16'h0046);
        wait_empty("mid_mac");

        // Reset in the middle of MAC abandons the START
        do_cmd(OP_CLEAR, 16'h0, 1'b0, 1'b0, 16'h0);
        load_1_to_8();
        issue(8'h01, OP_START, 16'h0000, e);
        exp_busy(e + 2, 1'b0);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_rsp("reset_mid_mac", 32'h0);
        q.delete();
        m_ack       = 1'b0;
        last_w      = 32'h0;
        tog         = 1'b0;
        bus.cmd_in  = 32'h0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_rsp("after_mid_mac_reset", 32'h0);
        do_cmd(OP_READ_LO, 16'h0, 1'b0, 1'b0, 16'h0000);
        repeat (10) @(negedge clk);
        check_rsp("no_late_ack", last_w);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
